// File: rtl/fifo_readout_pkg.sv
// Shared defaults and state encoding for the ADC FIFO readout engine.
package fifo_readout_pkg;

   localparam int unsigned CNT_W_DEF       = 16;
   localparam int unsigned TIMEOUT_CYC_DEF = 1024;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StReq    = 3'd1,
      StWait   = 3'd2,
      StSend   = 3'd3,
      StFinish = 3'd4
   } rd_state_e;

endpackage

// File: rtl/fifo_readout_timer.sv
// Counts consecutive empty-FIFO cycles; expired_o flags the last tolerated one.
module fifo_readout_timer #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] r_cnt;

   // Asserted while the counter sits on the final cycle, so an enabled cycle here is the last one.
   assign expired_o = (r_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!reset || clear_i) begin
         r_cnt <= '0;
      end else if (en_i && !expired_o) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_readout.sv
// Reads bytes from the ADC FIFO and hands them to the serial transmitter.
module fifo_readout
   import fifo_readout_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] byte_count_i,
   input  logic             fifo_empty_i,
   input  logic [7:0]       fifo_data_i,
   output logic             fifo_rd_en_o,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             underrun_o,
   output logic [CNT_W-1:0] bytes_sent_o
);

   rd_state_e        r_state,    w_state_nxt;
   logic [CNT_W-1:0] r_count,    w_count_nxt;
   logic [CNT_W-1:0] r_sent,     w_sent_nxt;
   logic [7:0]       r_tx_data,  w_tx_data_nxt;
   logic             r_underrun, w_underrun_nxt;

   logic             w_rd_en;
   logic             w_tmr_en;
   logic             w_tmr_clr;
   logic             w_expired;
   logic             w_count_zero;
   logic [CNT_W-1:0] w_sent_inc;

   assign w_count_zero = (r_count == '0);
   // Saturating increment keeps drain mode from wrapping.
   assign w_sent_inc   = (r_sent == '1) ? r_sent : r_sent + 1'b1;
   assign w_tmr_clr    = (r_state != StReq) || w_rd_en;

   fifo_readout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (w_tmr_clr),
      .en_i      (w_tmr_en),
      .expired_o (w_expired)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_sent_nxt     = r_sent;
      w_tx_data_nxt  = r_tx_data;
      w_underrun_nxt = r_underrun;
      w_rd_en        = 1'b0;
      w_tmr_en       = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (start_i && !abort_i) begin
               w_count_nxt    = byte_count_i;
               w_sent_nxt     = '0;
               w_underrun_nxt = 1'b0;
               w_state_nxt    = StReq;
            end
         end
         StReq: begin
            if (abort_i) begin
               w_state_nxt = StFinish;
            end else if (!fifo_empty_i) begin
               w_rd_en     = 1'b1;
               w_state_nxt = StWait;
            end else if (w_count_zero) begin
               w_state_nxt = StFinish;
            end else begin
               w_tmr_en = 1'b1;
               if (w_expired) begin
                  w_underrun_nxt = 1'b1;
                  w_state_nxt    = StFinish;
               end
            end
         end
         StWait: begin
            if (abort_i) begin
               w_state_nxt = StFinish;
            end else begin
               w_tx_data_nxt = fifo_data_i;
               w_state_nxt   = StSend;
            end
         end
         StSend: begin
            // A handshake in the abort cycle still counts the byte.
            if (tx_ready_i) begin
               w_sent_nxt = w_sent_inc;
               if (abort_i || (!w_count_zero && (w_sent_inc == r_count))) begin
                  w_state_nxt = StFinish;
               end else begin
                  w_state_nxt = StReq;
               end
            end else if (abort_i) begin
               w_state_nxt = StFinish;
            end
         end
         StFinish: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_count    <= '0;
         r_sent     <= '0;
         r_tx_data  <= 8'h00;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_sent     <= w_sent_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   assign fifo_rd_en_o = w_rd_en;
   assign tx_data_o    = r_tx_data;
   assign tx_valid_o   = (r_state == StSend);
   assign busy_o       = (r_state != StIdle);
   assign done_o       = (r_state == StFinish);
   assign underrun_o   = r_underrun;
   assign bytes_sent_o = r_sent;

endmodule

// File: tb/tb_fifo_readout.sv
// Directed bench for fifo_readout: vector table of whole readouts plus corner-case sequences.
module tb_fifo_readout;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned TMO   = 16;

   logic             clk          = 1'b0;
   logic             reset        = 1'b0;
   logic             start_i      = 1'b0;
   logic             abort_i      = 1'b0;
   logic [CNT_W-1:0] byte_count_i = '0;
   logic             fifo_empty_i = 1'b1;
   logic [7:0]       fifo_data_i  = 8'h00;
   logic             tx_ready_i   = 1'b1;
   logic             fifo_rd_en_o;
   logic [7:0]       tx_data_o;
   logic             tx_valid_o;
   logic             busy_o;
   logic             done_o;
   logic             underrun_o;
   logic [CNT_W-1:0] bytes_sent_o;

   fifo_readout #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .byte_count_i (byte_count_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .tx_data_o    (tx_data_o),
      .tx_valid_o   (tx_valid_o),
      .tx_ready_i   (tx_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .underrun_o   (underrun_o),
      .bytes_sent_o (bytes_sent_o)
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   logic [7:0] rx[$];
   int  n_checks    = 0;
   int  n_errors    = 0;
   int  rd_pulses   = 0;
   int  done_pulses = 0;
   int  rd_viol     = 0;
   int  stab_viol   = 0;
   bit  rd_seen     = 1'b0;
   bit  pend        = 1'b0;
   logic [7:0] pend_data = 8'h00;

   // Monitor samples mid-cycle, well away from the rising edge.
   always @(negedge clk) begin
      rd_seen = fifo_rd_en_o;
      if (fifo_rd_en_o) rd_pulses++;
      if (fifo_rd_en_o && fifo_empty_i) rd_viol++;
      if (done_o) done_pulses++;
      if (pend && tx_valid_o && (tx_data_o != pend_data)) stab_viol++;
      pend      = tx_valid_o && !tx_ready_i;
      pend_data = tx_data_o;
      if (tx_valid_o && tx_ready_i) rx.push_back(tx_data_o);
   end

   // FIFO stimulus: a read seen in one cycle presents its data in the next.
   always @(posedge clk) begin
      #1;
      if (rd_seen && (fq.size() > 0)) fifo_data_i = fq.pop_front();
      fifo_empty_i = (fq.size() == 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_run(input int cnt);
      byte_count_i = CNT_W'(cnt);
      start_i      = 1'b1;
      tick();
      start_i      = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cyc++;
         if (done_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk("valid_seen", 32'(seen), 32'd1);
   endtask

   task automatic preload(input int n, input int base);
      fq.delete();
      for (int i = 0; i < n; i++) fq.push_back(8'((base + i) & 255));
      tick();
   endtask

   typedef struct {
      string name;
      int    count;
      int    nfill;
      int    base;
      int    exp_sent;
      int    exp_und;
      int    exp_cyc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int cyc;
      int rd0;
      int d0;

      vecs[0] = '{"cnt4",     4, 4, 'hA1, 4, 0, 13};
      vecs[1] = '{"drain3",   0, 3, 'h31, 3, 0, 11};
      vecs[2] = '{"underrun", 5, 2, 'h51, 2, 1, 23};
      vecs[3] = '{"cnt2of5",  2, 5, 'h21, 2, 0, 7};
      vecs[4] = '{"drain0",   0, 0, 'h00, 0, 0, 2};
      vecs[5] = '{"cnt1",     1, 1, 'hF0, 1, 0, 4};

      repeat (3) tick();
      chk("rst_rd_en",    32'(fifo_rd_en_o), 32'd0);
      chk("rst_valid",    32'(tx_valid_o),   32'd0);
      chk("rst_busy",     32'(busy_o),       32'd0);
      chk("rst_done",     32'(done_o),       32'd0);
      chk("rst_underrun", 32'(underrun_o),   32'd0);
      chk("rst_tx_data",  32'(tx_data_o),    32'd0);
      chk("rst_sent",     32'(bytes_sent_o), 32'd0);
      reset = 1'b1;
      tick();

      foreach (vecs[k]) begin
         preload(vecs[k].nfill, vecs[k].base);
         rx.delete();
         rd0 = rd_pulses;
         d0  = done_pulses;
         start_run(vecs[k].count);
         wait_done(100, cyc);
         chk({vecs[k].name, "_cycles"}, 32'(cyc), 32'(vecs[k].exp_cyc));
         tick();
         tick();
         chk({vecs[k].name, "_sent"},     32'(bytes_sent_o),    32'(vecs[k].exp_sent));
         chk({vecs[k].name, "_underrun"}, 32'(underrun_o),      32'(vecs[k].exp_und));
         chk({vecs[k].name, "_busy"},     32'(busy_o),          32'd0);
         chk({vecs[k].name, "_dones"},    32'(done_pulses - d0), 32'd1);
         chk({vecs[k].name, "_rd"},       32'(rd_pulses - rd0),  32'(vecs[k].exp_sent));
         chk({vecs[k].name, "_rx_n"},     32'(rx.size()),        32'(vecs[k].exp_sent));
         for (int i = 0; i < rx.size(); i++) begin
            chk({vecs[k].name, "_rx_byte"}, 32'(rx[i]), 32'((vecs[k].base + i) & 255));
         end
      end

      // Transmitter stall on the second byte.
      preload(3, 'hB1);
      rx.delete();
      rd0 = rd_pulses;
      tx_ready_i = 1'b1;
      start_run(3);
      for (int i = 0; i < 20 && rx.size() < 1; i++) @(negedge clk);
      @(posedge clk);
      #2;
      tx_ready_i = 1'b0;
      repeat (10) tick();
      chk("stall_valid", 32'(tx_valid_o),      32'd1);
      chk("stall_data",  32'(tx_data_o),       32'hB2);
      chk("stall_rd",    32'(rd_pulses - rd0), 32'd2);
      chk("stall_rx_n",  32'(rx.size()),       32'd1);
      tx_ready_i = 1'b1;
      wait_done(50, cyc);
      tick();
      chk("stall_sent", 32'(bytes_sent_o), 32'd3);
      chk("stall_rx_n_end", 32'(rx.size()), 32'd3);
      for (int i = 0; i < rx.size(); i++) chk("stall_rx_byte", 32'(rx[i]), 32'hB1 + 32'(i));

      // Abort while a byte waits for the transmitter.
      preload(4, 'hC1);
      rx.delete();
      rd0 = rd_pulses;
      tx_ready_i = 1'b0;
      start_run(4);
      wait_valid(20);
      @(posedge clk);
      #2;
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_valid", 32'(tx_valid_o),      32'd0);
      chk("abort_done",  32'(done_o),          32'd1);
      chk("abort_sent",  32'(bytes_sent_o),    32'd0);
      chk("abort_rd",    32'(rd_pulses - rd0), 32'd1);
      tick();
      chk("abort_idle",  32'(busy_o),          32'd0);
      preload(1, 'h77);
      tx_ready_i = 1'b1;
      rx.delete();
      start_run(1);
      wait_done(20, cyc);
      tick();
      chk("restart_sent", 32'(bytes_sent_o), 32'd1);
      chk("restart_rx_n", 32'(rx.size()),    32'd1);
      if (rx.size() > 0) chk("restart_rx_byte", 32'(rx[0]), 32'h77);

      // Handshake and abort in the same cycle.
      preload(3, 'hD1);
      rx.delete();
      tx_ready_i = 1'b0;
      start_run(3);
      wait_valid(20);
      @(posedge clk);
      #2;
      tx_ready_i = 1'b1;
      abort_i    = 1'b1;
      tick();
      abort_i    = 1'b0;
      chk("hs_abort_done",  32'(done_o),       32'd1);
      chk("hs_abort_sent",  32'(bytes_sent_o), 32'd1);
      chk("hs_abort_valid", 32'(tx_valid_o),   32'd0);
      chk("hs_abort_rx_n",  32'(rx.size()),    32'd1);
      tick();

      // Start and abort together in IDLE.
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      chk("start_abort_busy", 32'(busy_o), 32'd0);
      tick();
      chk("start_abort_busy2", 32'(busy_o), 32'd0);

      // Reset during WAIT.
      preload(3, 'hE1);
      d0 = done_pulses;
      start_run(3);
      tick();
      reset = 1'b0;
      tick();
      chk("wrst_rd_en",    32'(fifo_rd_en_o), 32'd0);
      chk("wrst_valid",    32'(tx_valid_o),   32'd0);
      chk("wrst_busy",     32'(busy_o),       32'd0);
      chk("wrst_done",     32'(done_o),       32'd0);
      chk("wrst_underrun", 32'(underrun_o),   32'd0);
      chk("wrst_tx_data",  32'(tx_data_o),    32'd0);
      chk("wrst_sent",     32'(bytes_sent_o), 32'd0);
      reset = 1'b1;
      tick();
      chk("wrst_no_done", 32'(done_pulses - d0), 32'd0);

      // Start with the FIFO empty: no read may ever be issued.
      preload(0, 0);
      tick();
      rd0 = rd_pulses;
      start_run(3);
      repeat (5) tick();
      chk("empty_busy", 32'(busy_o), 32'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
      tick();
      chk("empty_rd",       32'(rd_pulses - rd0), 32'd0);
      chk("empty_idle",     32'(busy_o),          32'd0);
      chk("empty_underrun", 32'(underrun_o),      32'd0);

      chk("rd_while_empty", 32'(rd_viol),   32'd0);
      chk("tx_data_stable", 32'(stab_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
